// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with front/back buffer swap handshake
//
// Ports:
//   clk                      system clock; pixels advance every second clk
//   rst                      asynchronous active-low reset
//   in_red/in_green/in_blue  frame-buffer pixel, valid one pixel period after hc/vc addressed it
//   swap_req                 level request to flip front/back buffers
//   hc, vc                   current pixel column / line (frame-buffer address)
//   hsync, vsync             active-low sync, aligned with red/green/blue at the pins
//   red, green, blue         4-bit DAC colour, forced to 0 outside the visible area
//   front_sel                buffer currently scanned out
//   swap_ack                 one-clk pulse when front_sel flips
//   frame_start              one-clk pulse when hc/vc wrap to 0/0
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] in_red,
    input  logic [2:0] in_green,
    input  logic [1:0] in_blue,
    input  logic       swap_req,
    output logic [9:0] hc,
    output logic [9:0] vc,
    output logic       hsync,
    output logic       vsync,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       front_sel,
    output logic       swap_ack,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PENDING,
        S_FLIP,
        S_WAIT_LOW
    } swap_state_e;

    logic        pix_en_q;
    logic [9:0]  hc_q, hc_d;
    logic [9:0]  vc_q, vc_d;
    logic        frame_start_q, frame_start_d;
    logic        hsync_raw, vsync_raw, active_raw;
    logic        hsync_p_q, vsync_p_q, active_p_q;
    logic        hsync_q, vsync_q;
    logic [3:0]  red_q, green_q, blue_q;
    logic        flip_point;
    swap_state_e state_q, state_d;
    logic        front_sel_q, front_sel_d;
    logic        swap_ack_q, swap_ack_d;

    always_comb begin
        hc_d          = hc_q;
        vc_d          = vc_q;
        frame_start_d = 1'b0;
        if (pix_en_q) begin
            if (hc_q == H_LAST) begin
                hc_d = '0;
                if (vc_q == V_LAST) begin
                    vc_d          = '0;
                    frame_start_d = 1'b1;
                end else begin
                    vc_d = vc_q + 10'd1;
                end
            end else begin
                hc_d = hc_q + 10'd1;
            end
        end
    end

    assign hsync_raw  = ~((hc_q >= H_SYNC_BEG) && (hc_q < H_SYNC_END));
    assign vsync_raw  = ~((vc_q >= V_SYNC_BEG) && (vc_q < V_SYNC_END));
    assign active_raw = (hc_q < H_VIS) && (vc_q < V_VIS);

    // Two-stage alignment. On the pix_en edge that retires pixel N the sync and
    // active flags of N are captured (one pixel delay). On the following
    // mid-pixel edge the RAM data for N has settled, so colour and the delayed
    // syncs are loaded together and leave the chip in the same clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_en_q      <= 1'b0;
            hc_q          <= '0;
            vc_q          <= '0;
            frame_start_q <= 1'b0;
            hsync_p_q     <= 1'b1;
            vsync_p_q     <= 1'b1;
            active_p_q    <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
        end else begin
            pix_en_q      <= ~pix_en_q;
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            frame_start_q <= frame_start_d;
            if (pix_en_q) begin
                hsync_p_q  <= hsync_raw;
                vsync_p_q  <= vsync_raw;
                active_p_q <= active_raw;
            end else begin
                hsync_q <= hsync_p_q;
                vsync_q <= vsync_p_q;
                red_q   <= active_p_q ? {in_red, in_red[2]}     : 4'd0;
                green_q <= active_p_q ? {in_green, in_green[2]} : 4'd0;
                blue_q  <= active_p_q ? {in_blue, in_blue}      : 4'd0;
            end
        end
    end

    // The only flip opportunity is the pixel period of hc=0 on the first
    // blanking line, so the buffer never changes while visible lines are drawn.
    assign flip_point = pix_en_q && (hc_q == '0) && (vc_q == V_VIS);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            front_sel_q <= 1'b0;
            swap_ack_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            front_sel_q <= front_sel_d;
            swap_ack_q  <= swap_ack_d;
        end
    end

    // front_sel and swap_ack change on the edge that enters FLIP, so the ack
    // pulse spans exactly the FLIP clk. WAIT_LOW demands swap_req drop before
    // another request can be accepted.
    always_comb begin
        state_d     = state_q;
        front_sel_d = front_sel_q;
        swap_ack_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (swap_req) begin
                    state_d = S_PENDING;
                end
            end
            S_PENDING: begin
                if (flip_point) begin
                    state_d     = S_FLIP;
                    front_sel_d = ~front_sel_q;
                    swap_ack_d  = 1'b1;
                end
            end
            S_FLIP: begin
                state_d = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                if (!swap_req) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign hc          = hc_q;
    assign vc          = vc_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;
    assign front_sel   = front_sel_q;
    assign swap_ack    = swap_ack_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen on a reduced raster
module tb_vga_timing_gen;

    localparam int HA = 16;
    localparam int HF = 2;
    localparam int HS = 4;
    localparam int HB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VA = 12;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int VT = VA + VF + VS + VB;
    localparam int FP = HT * VT;

    logic       clk;
    logic       rst;
    logic [2:0] in_red;
    logic [2:0] in_green;
    logic [1:0] in_blue;
    logic       swap_req;
    logic [9:0] hc;
    logic [9:0] vc;
    logic       hsync;
    logic       vsync;
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
    logic       front_sel;
    logic       swap_ack;
    logic       frame_start;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .rst(rst),
        .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
        .swap_req(swap_req),
        .hc(hc), .vc(vc), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue),
        .front_sel(front_sel), .swap_ack(swap_ack), .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_fail = 0;
    int         kclk;
    logic [2:0] cap_r;
    logic [2:0] cap_g;
    logic [1:0] cap_b;
    logic       exp_fs;

    // kclk = number of clk edges since reset release; pixel data is taken on odd edges
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            kclk <= 0;
        end else begin
            kclk <= kclk + 1;
            if (kclk % 2 == 0) begin
                cap_r <= in_red;
                cap_g <= in_green;
                cap_b <= in_blue;
            end
        end
    end

    function automatic int m_pin(int k);
        return (k - 1) / 2 - 1;
    endfunction

    function automatic logic m_hs(int p);
        int c;
        if (p < 0) return 1'b1;
        c = p % HT;
        return !((c >= HA + HF) && (c < HA + HF + HS));
    endfunction

    function automatic logic m_vs(int p);
        int r;
        if (p < 0) return 1'b1;
        r = (p / HT) % VT;
        return !((r >= VA + VF) && (r < VA + VF + VS));
    endfunction

    function automatic logic m_act(int p);
        if (p < 0) return 1'b0;
        return ((p % HT) < HA) && (((p / HT) % VT) < VA);
    endfunction

    function automatic logic m_fs(int k);
        return (k > 0) && (k % 2 == 0) && ((k / 2) % FP == 0);
    endfunction

    function automatic int next_flip(int kr);
        int k;
        k = 2 * (VA * HT + 1);
        while (k <= kr) k += 2 * FP;
        return k;
    endfunction

    task automatic test_reset();
        in_red   = 3'b111;
        in_green = 3'b111;
        in_blue  = 2'b11;
        swap_req = 1'b1;
        rst      = 1'b0;
        repeat (4) begin
            @(negedge clk);
            n_cmp++;
            if ({hc, vc, hsync, vsync, red, green, blue, front_sel, swap_ack, frame_start} !== {10'd0, 10'd0, 1'b1, 1'b1, 12'd0, 3'b000}) begin
                n_fail++;
                $display("FAIL reset_state got=%0h exp=%0h", {hc, vc, hsync, vsync, red, green, blue, front_sel, swap_ack, frame_start}, {10'd0, 10'd0, 1'b1, 1'b1, 12'd0, 3'b000});
            end
        end
        swap_req = 1'b0;
        rst      = 1'b1;
        exp_fs   = 1'b0;
    endtask

    task automatic test_timing();
        int p;
        int k;
        int fs_cnt;
        logic [19:0] e_pos;
        logic [2:0]  e_sync;
        logic [11:0] e_col;
        fs_cnt = 0;
        while (kclk < 4 * FP) begin
            @(negedge clk);
            k = kclk;
            p = m_pin(k);
            e_pos  = {10'((k / 2) % HT), 10'((k / 2 / HT) % VT)};
            e_sync = {m_hs(p), m_vs(p), m_fs(k)};
            e_col  = m_act(p) ? {cap_r, cap_r[2], cap_g, cap_g[2], cap_b, cap_b} : 12'd0;
            n_cmp++;
            if ({hc, vc} !== e_pos) begin
                n_fail++;
                $display("FAIL timing_pos k=%0d got=%0h exp=%0h", k, {hc, vc}, e_pos);
            end
            n_cmp++;
            if ({hsync, vsync, frame_start} !== e_sync) begin
                n_fail++;
                $display("FAIL timing_sync k=%0d got=%0b exp=%0b", k, {hsync, vsync, frame_start}, e_sync);
            end
            n_cmp++;
            if ({red, green, blue} !== e_col) begin
                n_fail++;
                $display("FAIL timing_colour k=%0d got=%0h exp=%0h", k, {red, green, blue}, e_col);
            end
            n_cmp++;
            if ({front_sel, swap_ack} !== 2'b00) begin
                n_fail++;
                $display("FAIL timing_swap_idle k=%0d got=%0b exp=00", k, {front_sel, swap_ack});
            end
            if (frame_start === 1'b1) fs_cnt++;
            in_red   = 3'($urandom);
            in_green = 3'($urandom);
            in_blue  = 2'($urandom);
        end
        n_cmp++;
        if (fs_cnt !== 2) begin
            n_fail++;
            $display("FAIL frame_start_count got=%0d exp=2", fs_cnt);
        end
    endtask

    task automatic test_colour_const();
        int p;
        int col;
        int row;
        int kend;
        in_red   = 3'b101;
        in_green = 3'b011;
        in_blue  = 2'b10;
        repeat (3) @(negedge clk);
        kend = kclk + 2 * FP;
        while (kclk < kend) begin
            @(negedge clk);
            p   = m_pin(kclk);
            col = p % HT;
            row = (p / HT) % VT;
            n_cmp++;
            if ({red, green, blue} !== (m_act(p) ? 12'hB6A : 12'h000)) begin
                n_fail++;
                $display("FAIL const_colour k=%0d got=%0h exp=%0h", kclk, {red, green, blue}, (m_act(p) ? 12'hB6A : 12'h000));
            end
            if (row < VA && col == HA - 1) begin
                n_cmp++;
                if ({red, green, blue, hsync} !== 13'h16D5) begin
                    n_fail++;
                    $display("FAIL col_last_visible k=%0d got=%0h exp=16d5", kclk, {red, green, blue, hsync});
                end
            end
            if (row < VA && col == HA) begin
                n_cmp++;
                if ({red, green, blue, hsync} !== 13'h0001) begin
                    n_fail++;
                    $display("FAIL col_first_blank k=%0d got=%0h exp=1", kclk, {red, green, blue, hsync});
                end
            end
            if (col == HA + HF) begin
                n_cmp++;
                if ({red, green, blue, hsync} !== 13'h0000) begin
                    n_fail++;
                    $display("FAIL hsync_first_low k=%0d got=%0h exp=0", kclk, {red, green, blue, hsync});
                end
            end
        end
    endtask

    task automatic test_swap_basic();
        int nt;
        int kf;
        int kend;
        nt = (kclk / 2 / FP + 1) * FP + (1 + $urandom_range(VA - 3)) * HT + $urandom_range(HT - 1);
        while (kclk < 2 * nt) @(negedge clk);
        swap_req = 1'b1;
        kf   = next_flip(2 * nt + 1);
        kend = kf + 2 * FP + 20;
        while (kclk < kend) begin
            @(negedge clk);
            n_cmp++;
            if ({front_sel, swap_ack} !== {exp_fs ^ (kclk >= kf), (kclk == kf)}) begin
                n_fail++;
                $display("FAIL swap_basic k=%0d flip_k=%0d got=%0b exp=%0b", kclk, kf, {front_sel, swap_ack}, {exp_fs ^ (kclk >= kf), (kclk == kf)});
            end
            if (kclk == kf + 2 * FP + 10) swap_req = 1'b0;
        end
        exp_fs = ~exp_fs;
    endtask

    task automatic test_reset_midswap();
        int nt;
        int p;
        int k;
        nt = (kclk / 2 / FP + 1) * FP + (VA / 2 + 1) * HT + $urandom_range(HT - 1);
        while (kclk < 2 * nt) @(negedge clk);
        swap_req = 1'b1;
        repeat (6) begin
            @(negedge clk);
            n_cmp++;
            if ({front_sel, swap_ack} !== {exp_fs, 1'b0}) begin
                n_fail++;
                $display("FAIL midswap_pending k=%0d got=%0b exp=%0b", kclk, {front_sel, swap_ack}, {exp_fs, 1'b0});
            end
        end
        #1 rst = 1'b0;
        swap_req = 1'b0;
        #1;
        exp_fs = 1'b0;
        n_cmp++;
        if ({hc, vc, hsync, vsync, red, green, blue, front_sel, swap_ack, frame_start} !== {10'd0, 10'd0, 1'b1, 1'b1, 12'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL async_reset_state got=%0h exp=%0h", {hc, vc, hsync, vsync, red, green, blue, front_sel, swap_ack, frame_start}, {10'd0, 10'd0, 1'b1, 1'b1, 12'd0, 3'b000});
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        while (kclk < 4 * FP + 4) begin
            @(negedge clk);
            k = kclk;
            p = m_pin(k);
            n_cmp++;
            if ({hc, vc, hsync, vsync, frame_start, front_sel, swap_ack} !== {10'((k / 2) % HT), 10'((k / 2 / HT) % VT), m_hs(p), m_vs(p), m_fs(k), 2'b00}) begin
                n_fail++;
                $display("FAIL post_reset k=%0d got=%0h exp=%0h", k, {hc, vc, hsync, vsync, frame_start, front_sel, swap_ack}, {10'((k / 2) % HT), 10'((k / 2 / HT) % VT), m_hs(p), m_vs(p), m_fs(k), 2'b00});
            end
        end
    endtask

    task automatic test_swap_deferred();
        int nt;
        int kf;
        nt = (kclk / 2 / FP + 1) * FP + VA * HT + 1 + $urandom_range(HT - 2);
        while (kclk < 2 * nt) @(negedge clk);
        swap_req = 1'b1;
        kf = next_flip(2 * nt + 1);
        while (kclk < kf + 20) begin
            @(negedge clk);
            n_cmp++;
            if ({front_sel, swap_ack} !== {exp_fs ^ (kclk >= kf), (kclk == kf)}) begin
                n_fail++;
                $display("FAIL swap_deferred k=%0d flip_k=%0d got=%0b exp=%0b", kclk, kf, {front_sel, swap_ack}, {exp_fs ^ (kclk >= kf), (kclk == kf)});
            end
            if (kclk == kf + 4) swap_req = 1'b0;
        end
        exp_fs = ~exp_fs;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        rst      = 1'b0;
        swap_req = 1'b0;
        in_red   = 3'd0;
        in_green = 3'd0;
        in_blue  = 2'd0;
        test_reset();
        test_timing();
        test_colour_const();
        test_swap_basic();
        test_reset_midswap();
        test_swap_deferred();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameter V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical porch and sync widths in lines.
REQ-005 SHALL have port clk, input, 1, system clock (50 MHz); single clock domain.
REQ-006 SHALL have port rst, input, 1; reset is asynchronous and active-low.
REQ-007 SHALL have port in_red, input, 3, pixel red from frame buffer.
REQ-008 SHALL have port in_green, input, 3, pixel green.
REQ-009 SHALL have port in_blue, input, 2, pixel blue.
REQ-010 SHALL have port swap_req, input, 1, level request from the graphics stage to flip front/back buffers.
REQ-011 SHALL have port hc, output, 10, current horizontal pixel count.
REQ-012 SHALL have port vc, output, 10, current line count.
REQ-013 SHALL have port hsync and vsync, output, 1 each, active-low sync.
REQ-014 SHALL have port red, green, blue, output, 4 each, DAC colour.
REQ-015 SHALL have port front_sel, output, 1, buffer currently scanned out.
REQ-016 SHALL have port swap_ack, output, 1, one-clk pulse confirming a flip.
REQ-017 SHALL have port frame_start, output, 1, one-clk pulse at hc=0, vc=0.

Function
REQ-018 SHALL generate pix_en internally, toggling every clk (25 MHz pixel rate); pix_en high in the first clk after reset release.
REQ-019 SHALL increment hc on each pix_en; wrap at H_TOTAL-1 (799 default) to 0 and increment vc.
REQ-020 SHALL wrap vc at V_TOTAL-1 (524 default) to 0 simultaneously with hc wrap.
REQ-021 SHALL define active = (hc < H_ACTIVE) and (vc < V_ACTIVE).
REQ-022 SHALL drive hsync low for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751), else high.
REQ-023 SHALL drive vsync low for vc in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491), else high.
REQ-024 SHALL treat in_* as valid one pixel period after the hc/vc that addressed them (1-pixel RAM latency).
REQ-025 SHALL delay hsync, vsync and active by one pixel period so colour and sync stay aligned at the pins.
REQ-026 SHALL register colour: red = {in_red, in_red[2]}, green = {in_green, in_green[2]}, blue = {in_blue, in_blue} when delayed active, else 0.
REQ-027 SHALL use a swap FSM: IDLE -> PENDING when swap_req=1; PENDING -> FLIP on first pix_en with hc=0 and vc=V_ACTIVE; FLIP -> WAIT_LOW (one clk: toggle front_sel, pulse swap_ack); WAIT_LOW -> IDLE when swap_req=0.
REQ-028 SHALL never flip front_sel during active video; a request raised at vc=V_ACTIVE after hc=0 waits for the next frame.
REQ-029 SHALL ignore swap_req held high after ack (at most one flip per request edge-cycle).
REQ-030 SHALL pulse frame_start for one clk on the pix_en cycle where hc and vc both become 0.

Reset
REQ-031 SHALL, while rst=0, force hc=0, vc=0, pix_en=0, FSM=IDLE, front_sel=0, swap_ack=0, frame_start=0, hsync=1, vsync=1, red/green/blue=0.
REQ-032 SHALL, on reset asserted mid-frame or mid-swap, abandon the pending swap; front_sel returns to 0.
REQ-033 SHALL resume counting from hc=0, vc=0 on release; first frame_start not issued until the first full wrap.

Verification
REQ-034 SHALL test: release reset, run 800*525*2 clks -> hsync low exactly 96 pixels per line, vsync low lines 490-491, one frame_start per 840000 clks.
REQ-035 SHALL test: in_red=3'b101, in_green=3'b011, in_blue=2'b10 constant -> red=4'hB, green=4'h6, blue=4'hA inside active region, all 0 in blanking.
REQ-036 SHALL test: swap_req=1 at vc=100 -> front_sel toggles once at hc=0, vc=480, swap_ack one clk; no second toggle while swap_req stays high.
REQ-037 SHALL test: swap_req raised at vc=480, hc=5 -> flip deferred to vc=480, hc=0 of next frame.
REQ-038 SHALL test: rst pulsed low at vc=300 with swap PENDING -> outputs at reset values immediately, front_sel=0, no swap_ack after release.
REQ-039 SHALL test: colour column at hc=639 visible, hc=640 blanked, confirming one-pixel alignment with delayed hsync.
